prog_fsm: RTL and testbench
===========================

PROG_FSM -- requirements
Module: prog_fsm

Interface
REQ-001 Parameter NREG, default 4: number of datapath registers driven, minimum 2.
REQ-002 Parameter SW, default 3: ALU operation select width.
REQ-003 Parameter CW, default 2: repeat-count field width.
REQ-004 Derived widths SHALL be fixed as follows.
- RW = $clog2(NREG)
- SELW = $clog2(NREG+1)
- IW = 2+3*RW+SW+CW
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start_i  in  1  request to execute instr_i.
REQ-008 instr_i  in  IW  instruction word; fields from MSB: op[1:0], dst[RW], srca[RW], srcb[RW], alu[SW], cnt[CW].
REQ-009 busy_o  out  1  high whenever the controller is not in IDLE.
REQ-010 done_o  out  1  one-cycle completion pulse.
REQ-011 err_o  out  1  one-cycle pulse, coincident with done_o, for an illegal instruction.
REQ-012 clr_o  out  1  synchronous clear of all datapath registers.
REQ-013 ce_o  out  NREG  one-hot register write enable.
REQ-014 ld_a_o  out  1  load ALU operand-A latch from the bus.
REQ-015 sel_o  out  SELW  bus mux select; 0..NREG-1 selects a register, NREG selects the external input.
REQ-016 s_o  out  SW  ALU operation select.

Function
REQ-017 States SHALL be IDLE, DECODE, CLEAR, LOAD, FETCHA, EXEC, DONE; state is registered and outputs are Moore, decoded from state plus the latched instruction.
REQ-018 IDLE: when start_i=1, instr_i SHALL be latched and the next state SHALL be DECODE; otherwise the controller remains in IDLE.
REQ-019 start_i SHALL be ignored in every state other than IDLE; the latched instruction SHALL NOT change while busy_o=1.
REQ-020 DECODE SHALL last one cycle and branch on op as follows.
- 00 -> CLEAR
- 01 -> LOAD
- 10 -> FETCHA, with the repeat counter loaded to cnt
- 11 -> DONE, with err flag set
REQ-021 CLEAR SHALL assert clr_o=1 for exactly one cycle, then go to DONE.
REQ-022 LOAD SHALL assert sel_o=NREG and ce_o[dst]=1 for one cycle, then go to DONE.
REQ-023 FETCHA SHALL assert ld_a_o=1 for one cycle and go to EXEC; sel_o SHALL be srca on the first iteration and dst on every later iteration.
REQ-024 EXEC SHALL assert sel_o=srcb, s_o=alu and ce_o[dst]=1 for one cycle.
- Counter = 0: next state DONE.
- Otherwise: decrement the counter and return to FETCHA.
REQ-025 An ALU instruction SHALL therefore perform cnt+1 iterations and occupy 2*(cnt+1) cycles between DECODE and DONE.
REQ-026 DONE SHALL assert done_o=1, and err_o=1 if the err flag is set, for one cycle, clear the err flag, and go to IDLE.
REQ-027 Latency from the start_i sampling edge to done_o high SHALL be exactly:
- CLR and LOAD: 3 cycles
- illegal op: 2 cycles
- ALU: 2*(cnt+1)+2 cycles
REQ-028 Outside the states named above, clr_o, ce_o, ld_a_o, sel_o and s_o SHALL all be 0; at most one ce_o bit SHALL be high in any cycle.
REQ-029 A dst, srca or srcb field value >= NREG (non-power-of-two NREG) SHALL be treated as an illegal instruction: DECODE SHALL go to DONE with err_o asserted.
REQ-030 The counter SHALL be CW bits wide and SHALL NOT wrap; cnt = 2^CW-1 yields exactly 2^CW iterations.
REQ-031 The earliest accepted back-to-back start SHALL be the cycle after DONE, i.e. the first IDLE cycle.

Reset
REQ-032 reset=1 at a rising edge SHALL force IDLE, clear the latched instruction, counter and err flag, and drive every output to 0 on the following cycle, regardless of current state.
REQ-033 reset SHALL take priority over start_i; a start_i coincident with reset SHALL be discarded.
REQ-034 Reset asserted mid-instruction SHALL produce no done_o pulse for the aborted instruction.

Verification (NREG=4, SW=3, CW=2)
REQ-035 The bench SHALL cover the following directed scenarios.
- Reset, then start_i with op=00 -> clr_o=1 in cycle 2, done_o=1 in cycle 3, busy_o=1 in cycles 1..3.
- LOAD with dst=2 -> sel_o=4 and ce_o=0100 in one cycle, done_o=1 the next cycle.
- ALU with srca=1, srcb=3, dst=0, alu=5, cnt=2 -> ld_a_o pulses with sel_o=1,0,0; EXEC cycles show sel_o=3, s_o=5, ce_o=0001 three times; done_o at cycle 8.
- op=11 -> done_o=1 and err_o=1 at cycle 2, and all datapath outputs stay 0.
- start_i held high throughout an ALU instruction -> the second instruction is accepted only in the first IDLE cycle after done_o.
- reset asserted during the second EXEC cycle -> all outputs 0 on the next cycle, busy_o=0, and no done_o pulse.

Source files
------------

// File: rtl/prog_fsm_if.sv
// Command/status bundle between an instruction source and the prog_fsm controller.
// Parameters must match those of the prog_fsm instance it is connected to.
interface prog_fsm_if #(
    parameter int NREG = 4,
    parameter int SW   = 3,
    parameter int CW   = 2
);
    localparam int RW   = $clog2(NREG);
    localparam int SELW = $clog2(NREG + 1);
    localparam int IW   = 2 + 3 * RW + SW + CW;

    logic            start_i;
    logic [IW-1:0]   instr_i;
    logic            busy_o;
    logic            done_o;
    logic            err_o;
    logic            clr_o;
    logic [NREG-1:0] ce_o;
    logic            ld_a_o;
    logic [SELW-1:0] sel_o;
    logic [SW-1:0]   s_o;

    modport master (
        output start_i, instr_i,
        input  busy_o, done_o, err_o, clr_o, ce_o, ld_a_o, sel_o, s_o
    );

    modport slave (
        input  start_i, instr_i,
        output busy_o, done_o, err_o, clr_o, ce_o, ld_a_o, sel_o, s_o
    );
endinterface

// File: rtl/prog_fsm.sv
// Microcoded register-file controller: decodes one instruction per start and
// sequences clear, load or repeated ALU operations on an NREG-register datapath.
module prog_fsm #(
    parameter int NREG = 4,
    parameter int SW   = 3,
    parameter int CW   = 2
) (
    input  logic      clk,
    input  logic      reset,
    prog_fsm_if.slave bus
);
    localparam int RW   = $clog2(NREG);
    localparam int SELW = $clog2(NREG + 1);
    localparam int IW   = 2 + 3 * RW + SW + CW;

    localparam logic [1:0] OP_CLR  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_ALU  = 2'b10;

    typedef enum logic [2:0] {
        IDLE, DECODE, CLEAR, LOAD, FETCHA, EXEC, DONE
    } state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] instr_q;
    logic [CW-1:0] cnt_q;
    logic          err_q;
    logic          first_q;

    logic [1:0]    f_op;
    logic [RW-1:0] f_dst, f_srca, f_srcb;
    logic [SW-1:0] f_alu;
    logic [CW-1:0] f_cnt;
    logic          illegal;

    assign f_op   = instr_q[IW-1 -: 2];
    assign f_dst  = instr_q[IW-3 -: RW];
    assign f_srca = instr_q[IW-3-RW -: RW];
    assign f_srcb = instr_q[IW-3-2*RW -: RW];
    assign f_alu  = instr_q[CW +: SW];
    assign f_cnt  = instr_q[CW-1:0];

    // Register indices can exceed NREG-1 only when NREG is not a power of two.
    assign illegal = (f_op == 2'b11) ||
                     (int'(f_dst)  >= NREG) ||
                     (int'(f_srca) >= NREG) ||
                     (int'(f_srcb) >= NREG);

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            state   <= IDLE;
            instr_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (bus.start_i) instr_q <= bus.instr_i;
                DECODE: begin
                    first_q <= 1'b1;
                    if (illegal)               err_q <= 1'b1;
                    else if (f_op == OP_ALU)   cnt_q <= f_cnt;
                end
                EXEC: begin
                    first_q <= 1'b0;
                    if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
                end
                DONE: err_q <= 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        // NOTE: a default assignment before the case keeps every path driven,
        // so no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:   if (bus.start_i) state_nxt = DECODE;
            DECODE: begin
                if (illegal)                 state_nxt = DONE;
                else if (f_op == OP_CLR)     state_nxt = CLEAR;
                else if (f_op == OP_LOAD)    state_nxt = LOAD;
                else                         state_nxt = FETCHA;
            end
            CLEAR:  state_nxt = DONE;
            LOAD:   state_nxt = DONE;
            FETCHA: state_nxt = EXEC;
            EXEC:   state_nxt = (cnt_q == '0) ? DONE : FETCHA;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy_o = (state != IDLE);
        bus.done_o = 1'b0;
        bus.err_o  = 1'b0;
        bus.clr_o  = 1'b0;
        bus.ce_o   = '0;
        bus.ld_a_o = 1'b0;
        bus.sel_o  = '0;
        bus.s_o    = '0;
        case (state)
            CLEAR: bus.clr_o = 1'b1;
            LOAD: begin
                bus.sel_o = SELW'(NREG);
                bus.ce_o  = NREG'(1) << f_dst;
            end
            // Later iterations accumulate: operand A comes back from dst.
            FETCHA: begin
                bus.ld_a_o = 1'b1;
                bus.sel_o  = first_q ? SELW'(f_srca) : SELW'(f_dst);
            end
            EXEC: begin
                bus.sel_o = SELW'(f_srcb);
                bus.s_o   = f_alu;
                bus.ce_o  = NREG'(1) << f_dst;
            end
            DONE: begin
                bus.done_o = 1'b1;
                bus.err_o  = err_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_prog_fsm.sv
// Directed bench for prog_fsm (NREG=4, SW=3, CW=2): cycle-exact output traces
// per instruction type, back-to-back starts and mid-instruction reset.
module tb_prog_fsm;
    localparam int NREG = 4;
    localparam int SW   = 3;
    localparam int CW   = 2;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    prog_fsm_if #(.NREG(NREG), .SW(SW), .CW(CW)) bus ();

    prog_fsm #(.NREG(NREG), .SW(SW), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Observed vector: {busy, done, err, clr, ce[3:0], ld_a, sel[2:0], s[2:0]}
    function automatic logic [14:0] obs();
        return {bus.busy_o, bus.done_o, bus.err_o, bus.clr_o, bus.ce_o,
                bus.ld_a_o, bus.sel_o, bus.s_o};
    endfunction

    function automatic logic [14:0] ev(input logic b, input logic d, input logic e,
                                       input logic c, input logic [3:0] ce,
                                       input logic ld, input logic [2:0] sel,
                                       input logic [2:0] s);
        return {b, d, e, c, ce, ld, sel, s};
    endfunction

    function automatic logic [12:0] mk(input logic [1:0] op, input logic [1:0] dst,
                                       input logic [1:0] srca, input logic [1:0] srcb,
                                       input logic [2:0] alu, input logic [1:0] cnt);
        return {op, dst, srca, srcb, alu, cnt};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [12:0] instr);
        bus.start_i = 1'b1;
        bus.instr_i = instr;
        tick();
        bus.start_i = 1'b0;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        bus.start_i = 1'b1;
        bus.instr_i = mk(2'b00, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0);
        tick();
        reset       = 1'b0;
        bus.start_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (obs() !== 15'd0) begin
                n_bad++;
                $display("FAIL reset c%0d: got %h want %h", k, obs(), 15'd0);
            end
            tick();
        end
    endtask

    task automatic test_clear();
        logic [14:0] exp_v [4];
        exp_v[0] = ev(1, 0, 0, 0, 4'b0000, 0, 3'd0, 3'd0);
        exp_v[1] = ev(1, 0, 0, 1, 4'b0000, 0, 3'd0, 3'd0);
        exp_v[2] = ev(1, 1, 0, 0, 4'b0000, 0, 3'd0, 3'd0);
        exp_v[3] = 15'd0;
        issue(mk(2'b00, 2'd1, 2'd2, 2'd3, 3'd4, 2'd1));
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (obs() !== exp_v[k]) begin
                n_bad++;
                $display("FAIL clear c%0d: got %h want %h", k + 1, obs(), exp_v[k]);
            end
            tick();
        end
    endtask

    task automatic test_load();
        logic [14:0] exp_v [4];
        exp_v[0] = ev(1, 0, 0, 0, 4'b0000, 0, 3'd0, 3'd0);
        exp_v[1] = ev(1, 0, 0, 0, 4'b0100, 0, 3'd4, 3'd0);
        exp_v[2] = ev(1, 1, 0, 0, 4'b0000, 0, 3'd0, 3'd0);
        exp_v[3] = 15'd0;
        issue(mk(2'b01, 2'd2, 2'd1, 2'd3, 3'd6, 2'd3));
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (obs() !== exp_v[k]) begin
                n_bad++;
                $display("FAIL load c%0d: got %h want %h", k + 1, obs(), exp_v[k]);
            end
            tick();
        end
    endtask

    task automatic test_alu();
        logic [14:0] exp_v [9];
        exp_v[0] = ev(1, 0, 0, 0, 4'b0000, 0, 3'd0, 3'd0);
        exp_v[1] = ev(1, 0, 0, 0, 4'b0000, 1, 3'd1, 3'd0);
        exp_v[2] = ev(1, 0, 0, 0, 4'b0001, 0, 3'd3, 3'd5);
        exp_v[3] = ev(1, 0, 0, 0, 4'b0000, 1, 3'd0, 3'd0);
        exp_v[4] = ev(1, 0, 0, 0, 4'b0001, 0, 3'd3, 3'd5);
        exp_v[5] = ev(1, 0, 0, 0, 4'b0000, 1, 3'd0, 3'd0);
        exp_v[6] = ev(1, 0, 0, 0, 4'b0001, 0, 3'd3, 3'd5);
        exp_v[7] = ev(1, 1, 0, 0, 4'b0000, 0, 3'd0, 3'd0);
        exp_v[8] = 15'd0;
        issue(mk(2'b10, 2'd0, 2'd1, 2'd3, 3'd5, 2'd2));
        for (int k = 0; k < 9; k++) begin
            n_cmp++;
            if (obs() !== exp_v[k]) begin
                n_bad++;
                $display("FAIL alu c%0d: got %h want %h", k + 1, obs(), exp_v[k]);
            end
            tick();
        end
    endtask

    task automatic test_illegal();
        logic [14:0] exp_v [3];
        exp_v[0] = ev(1, 0, 0, 0, 4'b0000, 0, 3'd0, 3'd0);
        exp_v[1] = ev(1, 1, 1, 0, 4'b0000, 0, 3'd0, 3'd0);
        exp_v[2] = 15'd0;
        issue(mk(2'b11, 2'd3, 2'd2, 2'd1, 3'd7, 2'd3));
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (obs() !== exp_v[k]) begin
                n_bad++;
                $display("FAIL illegal c%0d: got %h want %h", k + 1, obs(), exp_v[k]);
            end
            tick();
        end
    endtask

    // cnt at its maximum: 4 EXEC cycles, done_o at cycle 2*4+2 = 10.
    task automatic test_max_cnt();
        int n_exec = 0;
        int done_at = 0;
        issue(mk(2'b10, 2'd3, 2'd0, 2'd2, 3'd7, 2'd3));
        for (int k = 1; k <= 20 && done_at == 0; k++) begin
            if (bus.ce_o === 4'b1000 && bus.s_o === 3'd7 && bus.sel_o === 3'd2) n_exec++;
            if (bus.done_o === 1'b1) done_at = k;
            tick();
        end
        n_cmp++;
        if (done_at != 10) begin
            n_bad++;
            $display("FAIL max_cnt latency: got %0d want %0d (0 = timeout)", done_at, 10);
        end
        n_cmp++;
        if (n_exec != 4) begin
            n_bad++;
            $display("FAIL max_cnt iterations: got %0d want %0d", n_exec, 4);
        end
        n_cmp++;
        if (obs() !== 15'd0) begin
            n_bad++;
            $display("FAIL max_cnt idle: got %h want %h", obs(), 15'd0);
        end
    endtask

    // start_i stays high; a LOAD presented mid-instruction must wait for IDLE.
    task automatic test_back_to_back();
        logic [14:0] exp_v [9];
        exp_v[0] = ev(1, 0, 0, 0, 4'b0000, 0, 3'd0, 3'd0);
        exp_v[1] = ev(1, 0, 0, 0, 4'b0000, 1, 3'd2, 3'd0);
        exp_v[2] = ev(1, 0, 0, 0, 4'b0010, 0, 3'd3, 3'd2);
        exp_v[3] = ev(1, 1, 0, 0, 4'b0000, 0, 3'd0, 3'd0);
        exp_v[4] = 15'd0;
        exp_v[5] = ev(1, 0, 0, 0, 4'b0000, 0, 3'd0, 3'd0);
        exp_v[6] = ev(1, 0, 0, 0, 4'b1000, 0, 3'd4, 3'd0);
        exp_v[7] = ev(1, 1, 0, 0, 4'b0000, 0, 3'd0, 3'd0);
        exp_v[8] = 15'd0;
        bus.start_i = 1'b1;
        bus.instr_i = mk(2'b10, 2'd1, 2'd2, 2'd3, 3'd2, 2'd0);
        tick();
        for (int k = 1; k <= 9; k++) begin
            n_cmp++;
            if (obs() !== exp_v[k-1]) begin
                n_bad++;
                $display("FAIL back_to_back c%0d: got %h want %h", k, obs(), exp_v[k-1]);
            end
            if (k == 1) bus.instr_i = mk(2'b01, 2'd3, 2'd0, 2'd0, 3'd0, 2'd0);
            if (k == 6) bus.start_i = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset_mid();
        logic [14:0] exp_v [5];
        exp_v[0] = ev(1, 0, 0, 0, 4'b0000, 0, 3'd0, 3'd0);
        exp_v[1] = ev(1, 0, 0, 0, 4'b0000, 1, 3'd1, 3'd0);
        exp_v[2] = ev(1, 0, 0, 0, 4'b0001, 0, 3'd3, 3'd5);
        exp_v[3] = ev(1, 0, 0, 0, 4'b0000, 1, 3'd0, 3'd0);
        exp_v[4] = ev(1, 0, 0, 0, 4'b0001, 0, 3'd3, 3'd5);
        issue(mk(2'b10, 2'd0, 2'd1, 2'd3, 3'd5, 2'd2));
        for (int k = 1; k <= 5; k++) begin
            n_cmp++;
            if (obs() !== exp_v[k-1]) begin
                n_bad++;
                $display("FAIL reset_mid c%0d: got %h want %h", k, obs(), exp_v[k-1]);
            end
            if (k == 5) reset = 1'b1;
            tick();
        end
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (obs() !== 15'd0) begin
                n_bad++;
                $display("FAIL reset_mid post c%0d: got %h want %h", k, obs(), 15'd0);
            end
            tick();
        end
    endtask

    initial begin
        reset       = 1'b1;
        bus.start_i = 1'b0;
        bus.instr_i = '0;
        test_reset();
        test_clear();
        test_load();
        test_alu();
        test_illegal();
        test_clear();
        test_max_cnt();
        test_back_to_back();
        test_reset_mid();
        test_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
